// File: rtl/ring_osc_meas_pkg.sv
// Shared types and Gray-code helpers for the ring-oscillator frequency meter.
// Helpers operate on 32-bit vectors; callers size-cast to their own width.
package ring_osc_meas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2
    } meas_state_t;

    localparam int unsigned GRAY_FN_W = 32;

    function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] g);
        logic [GRAY_FN_W-1:0] b;
        b[GRAY_FN_W-1] = g[GRAY_FN_W-1];
        for (int unsigned i = 0; i < GRAY_FN_W - 1; i++) begin
            b[GRAY_FN_W-2-i] = b[GRAY_FN_W-1-i] ^ g[GRAY_FN_W-2-i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/osc_gray_counter.sv
// Free-running Gray counter in the oscillator domain plus a two-flop
// synchronizer per bit into the system clock domain.
module osc_gray_counter
    import ring_osc_meas_pkg::*;
#(
    parameter int unsigned OSC_W = 6
) (
    input  logic             osc_in,
    input  logic             rst,
    input  logic             clk,
    output logic [OSC_W-1:0] gray_sync
);

    logic [OSC_W-1:0] gray_q;
    logic [OSC_W-1:0] gray_d;
    logic [OSC_W-1:0] bin_cur;
    logic [OSC_W-1:0] bin_nxt;
    logic [OSC_W-1:0] meta_q;
    logic [OSC_W-1:0] sync_q;

    // Increment in binary at OSC_W bits so the wrap back to 0 is exact
    // before re-encoding.
    always_comb begin
        bin_cur = OSC_W'(gray2bin(32'(gray_q)));
        bin_nxt = bin_cur + OSC_W'(1);
        gray_d  = OSC_W'(bin2gray(32'(bin_nxt)));
    end

    always_ff @(posedge osc_in or posedge rst) begin
        if (rst) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= gray_q;
            sync_q <= meta_q;
        end
    end

    assign gray_sync = sync_q;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, waits a settle time,
// then accumulates synchronized edge deltas over a fixed window with saturation.
module ring_osc_freq_meter
    import ring_osc_meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 1024,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned OSC_W         = 6,
    parameter int unsigned ACC_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             osc_in,
    output logic             osc_ena,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] count,
    output logic             overflow
);

    localparam int unsigned TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned SUM_W   = ((ACC_W > OSC_W) ? ACC_W : OSC_W) + 1;

    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [SUM_W-1:0] ACC_MAX_EXT = SUM_W'({ACC_W{1'b1}});

    logic [OSC_W-1:0] gray_sync;
    logic [OSC_W-1:0] cur;
    logic [OSC_W-1:0] delta;
    logic [SUM_W-1:0] sum;
    logic             sat;
    logic [ACC_W-1:0] acc_d;

    meas_state_t      state_q;
    logic [TMR_W-1:0] timer_q;
    logic [ACC_W-1:0] acc_q;
    logic             win_ovf_q;
    logic [OSC_W-1:0] prev_q;
    logic [ACC_W-1:0] count_q;
    logic             overflow_q;
    logic             osc_ena_q;
    logic             busy_q;
    logic             done_q;

    osc_gray_counter #(
        .OSC_W(OSC_W)
    ) u_osc_gray_counter (
        .osc_in   (osc_in),
        .rst      (rst),
        .clk      (clk),
        .gray_sync(gray_sync)
    );

    // Modular subtraction absorbs the Gray counter wrap as long as fewer than
    // 2^OSC_W edges arrive between samples.
    always_comb begin
        cur   = OSC_W'(gray2bin(32'(gray_sync)));
        delta = cur - prev_q;
        sum   = SUM_W'(acc_q) + SUM_W'(delta);
        sat   = (sum > ACC_MAX_EXT);
        acc_d = sat ? '1 : ACC_W'(sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            acc_q      <= '0;
            win_ovf_q  <= 1'b0;
            prev_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            osc_ena_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            prev_q <= cur;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= SETTLE;
                        timer_q    <= SETTLE_LOAD;
                        acc_q      <= '0;
                        win_ovf_q  <= 1'b0;
                        overflow_q <= 1'b0;
                        osc_ena_q  <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (timer_q == '0) begin
                        state_q <= GATE;
                        timer_q <= GATE_LOAD;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                GATE: begin
                    acc_q     <= acc_d;
                    win_ovf_q <= win_ovf_q | sat;
                    if (timer_q == '0) begin
                        state_q    <= IDLE;
                        count_q    <= acc_d;
                        overflow_q <= win_ovf_q | sat;
                        done_q     <= 1'b1;
                        osc_ena_q  <= 1'b0;
                        busy_q     <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    osc_ena_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign osc_ena  = osc_ena_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: doc/ring_osc_freq_meter.md
# ring_osc_freq_meter

Measures the frequency of a free-running ring oscillator, such as the NAND2 ring in the PVT monitor, against the system clock. On request the block enables the oscillator and lets it settle. It then counts oscillator rising edges over a fixed window of system-clock cycles and reports a saturating count. It is the consumer end of the oscillator's `ena`/`osc_out` pair: it drives `ena` and receives `osc_out`.

## Interface
- `GATE_CYCLES`, 1024: measurement window length, in `clk` cycles (≥1).
- `SETTLE_CYCLES`, 16: cycles with the oscillator enabled before counting starts (≥1).
- `OSC_W`, 6: width of the Gray counter in the oscillator domain. Requires f_osc/f_clk < 2^(OSC_W-1).
- `ACC_W`, 16: width of the result accumulator.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset, applied to both domains.
- `start` in 1: request one measurement; sampled only in IDLE.
- `osc_in` in 1: oscillator output, asynchronous to `clk`.
- `osc_ena` out 1: enable to the oscillator.
- `busy` out 1: high in SETTLE and GATE.
- `done` out 1: one-cycle pulse when `count` is updated.
- `count` out ACC_W: oscillator rising edges in the last window, saturating.
- `overflow` out 1: the last window saturated `count`.

## Operation
- Oscillator domain:
  - OSC_W-bit Gray-code counter clocked on `osc_in` rising edge.
  - Asynchronously cleared by `rst`.
  - Free-running; it is not cleared between measurements.
- CDC:
  - Two-flop synchronizer per Gray bit into `clk`, reset to 0.
  - Then Gray-to-binary conversion, giving `cur`.
- Delta: a `prev` register holds the previous `cur`. Each cycle, delta = (cur − prev) mod 2^OSC_W, then prev ← cur.
- States: IDLE, SETTLE, GATE.
  - IDLE: `osc_ena`=0. On `start`=1: go to SETTLE, clear the accumulator and `overflow`, load the timer with SETTLE_CYCLES−1.
  - SETTLE: `osc_ena`=1. Deltas are discarded (prev still tracks). When the timer reaches 0: go to GATE, load the timer with GATE_CYCLES−1.
  - GATE: `osc_ena`=1. Each cycle, acc ← min(acc + delta, 2^ACC_W−1); set `overflow` if the sum exceeds the maximum. When the timer reaches 0 (that cycle's delta is included): go to IDLE, load `count` ← final acc, pulse `done`.
- `osc_ena` falls in the first IDLE cycle after GATE. Edges still in the synchronizer then are not counted.
- `start` while `busy`=1 is ignored.
- `start` in the same cycle as `done` is accepted, because the state is already IDLE.
- `count`/`overflow` hold their value until the next `done`. `overflow` is cleared on start; `count` is not.
- A stopped or stuck oscillator gives delta 0 and a count of 0. This is not an error.

## Timing
- Reset values: `osc_ena`=0, `busy`=0, `done`=0, `count`=0, `overflow`=0, state IDLE, timer/acc/prev=0.
- `start` high in cycle T:
  - `busy` and `osc_ena` are high from T+1.
  - GATE spans T+1+SETTLE_CYCLES through T+SETTLE_CYCLES+GATE_CYCLES.
  - `done` pulses at T+SETTLE_CYCLES+GATE_CYCLES+1.
  - `count` is valid in the `done` cycle.
- Synchronizer latency is 2 cycles. It shifts both window edges equally, so the result is within ±1 of f_osc·GATE_CYCLES/f_clk.
- `rst` mid-measurement:
  - Immediately forces IDLE, `osc_ena`=0, and clears `count`.
  - No `done` is produced.
  - The oscillator-domain counter is cleared asynchronously.

## Structure
- Package `ring_osc_meas_pkg`:
  - state enum `meas_state_t` (IDLE, SETTLE, GATE);
  - function `gray2bin`;
  - function `bin2gray`.
- Sub-module `osc_gray_counter`: the oscillator-domain Gray counter plus the two-flop synchronizer. Parameter OSC_W; ports `osc_in`, `rst`, `clk`, `gray_sync`. It is the only logic clocked by `osc_in`.
- Top level: FSM, timer, delta, saturating accumulator, output registers.

## Test plan
- Basic measurement: `clk` 10 ns, `osc_in` period 20 ns, GATE_CYCLES=1024, SETTLE_CYCLES=16, pulse `start` → `done` exactly 1041 cycles later, `count` ∈ {511, 512, 513}, `overflow`=0.
- Fast oscillator: `osc_in` period 7 ns (ratio 1.43) → `count` ≈ 1463 ±1. Checks correct Gray wrap of the OSC_W=6 counter.
- Saturation: ACC_W=8, `osc_in` period 5 ns → `count`=255, `overflow`=1. A following measurement at 40 ns period returns `count` ≈ 256 → clamps to 255, `overflow`=1. At GATE_CYCLES=400 the same run gives `count`=100, `overflow`=0.
- Dead oscillator: `osc_in` held 0 → `count`=0, `overflow`=0, `done` at the nominal cycle.
- Busy/back-to-back: `start` pulsed mid-GATE → ignored, only one `done`. `start` held high → a new SETTLE starts the cycle after `done`, and `busy` rises at `done`+1.
- Reset mid-GATE: assert `rst` 500 cycles into GATE → `osc_ena`, `busy`, `count` drop to 0 at once, no `done`. A fresh measurement afterwards gives a correct count.
